uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- UART receiver clocked by the board clock (clk_in).
- Recovers 8N1 (optionally parity) frames from the serial line, using the baud×16 oversampling clock produced by the UART clock generator as a sampling reference.
- Delivers each received byte with a one-cycle valid strobe to the level-meter/display logic.
- Flags framing and parity errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first, legal range 5..8.
- OVERSAMPLE, 16, sample strobes per bit period; must match the generator's uart_freq/baud_rate ratio.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk_in  input  1  board clock (50 MHz); every flop is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick_16x  input  1  baud×16 clock from the UART clock generator; treated as asynchronous data.
- rx  input  1  serial line; idles high; asynchronous.
- data_out  output  DATA_BITS  last received data word.
- data_valid  output  1  one clk_in pulse when a frame is received without error.
- frame_err  output  1  one clk_in pulse when the stop bit is sampled low.
- parity_err  output  1  one clk_in pulse when the parity check fails.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0.
  - FSM=IDLE, all counters 0.
  - Synchronizers: rx synchronizer to 1, tick synchronizer to 0.
- Synchronization:
  - rx and tick_16x each pass through a 2-FF synchronizer.
  - strobe = a 1-cycle pulse on each rising edge of the synchronized tick (a third flop provides the edge detect).
  - All bit timing counts strobes only. clk_in cycles between strobes are idle.
- tick_cnt:
  - log2(OVERSAMPLE) bits; increments on every strobe while not in IDLE and wraps at OVERSAMPLE-1.
  - A sample point is a strobe with tick_cnt = OVERSAMPLE/2-1 (7), i.e. mid-bit.
- bit_cnt: counts received data bits, 0..DATA_BITS-1.
- FSM states:
  - IDLE: when synchronized rx=0, go to START with tick_cnt=0 and busy=1. Detection acts on the clk_in edge at which synchronized rx is first seen low; no strobe is required.
  - START: at the sample point, if rx=0 go to DATA with bit_cnt=0 and tick_cnt restarted at 0. If rx=1 (glitch) go back to IDLE with no output pulse.
  - DATA:
    - Each later sample point is OVERSAMPLE strobes after the previous one.
    - At each sample point, rx is shifted into shift_reg at the MSB end, shifting right, so the LSB-first byte lands aligned.
    - After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: at the sample point, the parity bit is captured and the error is computed as XOR(data bits, parity bit) != PARITY_ODD. Then go to STOP.
  - STOP: at the sample point:
    - data_out <= shift_reg, always, even on error.
    - If rx=1 and parity is OK: data_valid=1 for one clk_in cycle, then IDLE.
    - If rx=1 and parity failed: parity_err=1 for one cycle, then IDLE.
    - If rx=0: frame_err=1 for one cycle (parity_err also pulses if parity failed), then go to BREAK.
  - BREAK: busy=1. Stay until synchronized rx=1, then go to IDLE. No new start bit is detected while the line is held low.
- Latency:
  - Output pulses are registered and assert on the clk_in edge after the stop-bit sample strobe is processed.
  - That point is ≈9.5 bit periods (no parity) after the start edge, plus up to 4 clk_in cycles of synchronizer and edge-detect delay.
- Back-to-back frames:
  - Stop-bit sampling happens mid-stop-bit, so IDLE is re-entered about half a bit before the next start edge.
  - A start edge that immediately follows the stop bit must be accepted.
- Output exclusivity: data_valid never asserts in the same cycle as frame_err or parity_err.
- Mid-frame reset: all state and outputs return to reset values at once. Reception restarts only on a new falling edge seen from IDLE.
- Stalled tick_16x: the FSM holds its state indefinitely. There is no timeout.
- Arithmetic: counters are unsigned and wrap modulo their width. There is no saturation logic.

Test Plan:
- clk_in 50 MHz, tick_16x 153.6 kHz; send 0xA5 at 9600 8N1 -> data_out=0xA5, a single data_valid pulse, frame_err=0, busy low after the pulse.
- Frames 0x00, 0xFF, 0x3C sent back-to-back with no idle gap -> three data_valid pulses, data_out 0x00 then 0xFF then 0x3C, no error pulses.
- rx low for 4 ticks (below half a bit), then high -> START aborts to IDLE; no data_valid, frame_err or parity_err; busy drops.
- Send 0x55 with the stop bit forced 0 and rx held low for 3 more bit times -> frame_err pulse, no data_valid, busy=1 until rx returns high; a following 0x12 frame is received correctly.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_err pulse, no data_valid, data_out=0x07. Resend with parity bit 1 -> data_valid pulse.
- Assert reset low during bit 4 of a 0xC3 frame -> all outputs 0 asynchronously, FSM=IDLE. After release, a fresh 0x81 frame -> data_out=0x81 with data_valid.

Source files
------------

// File: rtl/uart_rx_os.sv
// UART receiver on the board clock. The baud x16 tick is synchronized and
// edge-detected into a strobe, and all bit timing counts those strobes.
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD_SEL  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_r, state_nxt_s;
    logic                 rx_meta_r, rx_sync_r;
    logic                 tick_meta_r, tick_sync_r, tick_prev_r;
    logic                 strobe_s, sample_s;
    logic [TW-1:0]        tick_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_reg_r;
    logic                 par_bad_r;
    logic                 valid_s, ferr_s, perr_s, load_s;

    // True when received data plus parity bit do not match the selected parity.
    function automatic logic parity_fail_f(input logic [DATA_BITS-1:0] d, input logic p);
        return ((^d) ^ p) != ODD_SEL;
    endfunction

    // Two-flop synchronizers for rx and tick, plus a third tick flop for edge detect.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta_r   <= 1'b1;
            rx_sync_r   <= 1'b1;
            tick_meta_r <= 1'b0;
            tick_sync_r <= 1'b0;
            tick_prev_r <= 1'b0;
        end else begin
            rx_meta_r   <= rx;
            rx_sync_r   <= rx_meta_r;
            tick_meta_r <= tick_16x;
            tick_sync_r <= tick_meta_r;
            tick_prev_r <= tick_sync_r;
        end
    end

    assign strobe_s = tick_sync_r & ~tick_prev_r;

    // START samples at mid-bit; the counter is then realigned to 0, so later
    // sample points fall on the wrap, exactly OVERSAMPLE strobes apart.
    always_comb begin
        if (state_r == S_START) begin
            sample_s = strobe_s && (tick_cnt_r == MID_CNT);
        end else begin
            sample_s = strobe_s && (tick_cnt_r == LAST_CNT);
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:   if (!rx_sync_r) state_nxt_s = S_START; else state_nxt_s = S_IDLE;
            S_START:  if (sample_s) state_nxt_s = rx_sync_r ? S_IDLE : S_DATA; else state_nxt_s = S_START;
            S_DATA: begin
                if (sample_s && (bit_cnt_r == LAST_BIT)) begin
                    state_nxt_s = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    state_nxt_s = S_DATA;
                end
            end
            S_PARITY: if (sample_s) state_nxt_s = S_STOP; else state_nxt_s = S_PARITY;
            S_STOP:   if (sample_s) state_nxt_s = rx_sync_r ? S_IDLE : S_BREAK; else state_nxt_s = S_STOP;
            S_BREAK:  if (rx_sync_r) state_nxt_s = S_IDLE; else state_nxt_s = S_BREAK;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode: result pulses at the stop-bit sample point.
    always_comb begin
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        perr_s  = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            S_STOP: begin
                if (sample_s) begin
                    load_s  = 1'b1;
                    perr_s  = par_bad_r;
                    ferr_s  = ~rx_sync_r;
                    valid_s = rx_sync_r & ~par_bad_r;
                end else begin
                    load_s  = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Bit timing counters, shift register, parity status and registered outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_reg_r <= '0;
            par_bad_r   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (state_r == S_IDLE) begin
                tick_cnt_r <= '0;
            end else if (strobe_s) begin
                if ((state_r == S_START && sample_s) || tick_cnt_r == LAST_CNT) begin
                    tick_cnt_r <= '0;
                end else begin
                    tick_cnt_r <= tick_cnt_r + TW'(1);
                end
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end

            if (state_r == S_IDLE || state_r == S_START) begin
                bit_cnt_r <= '0;
            end else if (state_r == S_DATA && sample_s) begin
                bit_cnt_r   <= bit_cnt_r + BW'(1);
                shift_reg_r <= {rx_sync_r, shift_reg_r[DATA_BITS-1:1]};
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end

            if (state_r == S_IDLE) begin
                par_bad_r <= 1'b0;
            end else if (state_r == S_PARITY && sample_s) begin
                par_bad_r <= parity_fail_f(shift_reg_r, rx_sync_r);
            end else begin
                par_bad_r <= par_bad_r;
            end

            if (load_s) begin
                data_out <= shift_reg_r;
            end else begin
                data_out <= data_out;
            end
            data_valid <= valid_s;
            frame_err  <= ferr_s;
            parity_err <= perr_s;
            busy       <= (state_nxt_s != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: one 8N1 instance and one even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int BIT = 2560;   // 16 tick periods of 160 ns

    logic       clk_in = 1'b0;
    logic       tick_16x = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] data_out, data_out_p;
    logic       data_valid, frame_err, parity_err, busy;
    logic       data_valid_p, frame_err_p, parity_err_p, busy_p;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, excl_cnt = 0;
    int valid_cnt_p = 0, ferr_cnt_p = 0, perr_cnt_p = 0, excl_cnt_p = 0;
    logic [7:0] got_q[$];
    int v0, f0, p0, q0;

    uart_rx_os dut (
        .clk_in(clk_in), .reset(reset), .tick_16x(tick_16x), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    uart_rx_os #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk_in(clk_in), .reset(reset), .tick_16x(tick_16x), .rx(rx_p),
        .data_out(data_out_p), .data_valid(data_valid_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .busy(busy_p)
    );

    always #10 clk_in = ~clk_in;
    always #80 tick_16x = ~tick_16x;

    always @(negedge clk_in) begin
        if (data_valid) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(data_out);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
        if (data_valid && (frame_err || parity_err)) excl_cnt = excl_cnt + 1;
    end

    always @(negedge clk_in) begin
        if (data_valid_p) valid_cnt_p = valid_cnt_p + 1;
        if (frame_err_p) ferr_cnt_p = ferr_cnt_p + 1;
        if (parity_err_p) perr_cnt_p = perr_cnt_p + 1;
        if (data_valid_p && (frame_err_p || parity_err_p)) excl_cnt_p = excl_cnt_p + 1;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #BIT;
        end
        rx = stop;
        #BIT;
    endtask

    task automatic send_frame_p(input logic [7:0] b, input logic par);
        rx_p = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_p = b[i];
            #BIT;
        end
        rx_p = par;
        #BIT;
        rx_p = 1'b1;
        #BIT;
    endtask

    task automatic snap();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        q0 = got_q.size();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk_in);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        total++; if (busy !== 1'b0 || busy_p !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", busy, busy_p); end
        reset = 1'b1;
        #BIT;
    endtask

    task automatic test_basic();
        snap();
        send_frame(8'hA5, 1'b1);
        #BIT;
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL basic_valid_cnt got=%0d exp=1", valid_cnt - v0); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", data_out); end
        total++; if (got_q.size() > q0 && got_q[q0] !== 8'hA5) begin bad++; $display("FAIL basic_strobe_data got=%h exp=a5", got_q[q0]); end
        total++; if (ferr_cnt - f0 !== 0 || perr_cnt - p0 !== 0) begin bad++; $display("FAIL basic_err got=%0d/%0d exp=0/0", ferr_cnt - f0, perr_cnt - p0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[3];
        exp_b = '{8'h00, 8'hFF, 8'h3C};
        snap();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
        #BIT;
        total++; if (valid_cnt - v0 !== 3) begin bad++; $display("FAIL b2b_valid_cnt got=%0d exp=3", valid_cnt - v0); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_q.size() < q0 + i + 1) begin
                bad++; $display("FAIL b2b_data%0d got=none exp=%h", i, exp_b[i]);
            end else if (got_q[q0+i] !== exp_b[i]) begin
                bad++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got_q[q0+i], exp_b[i]);
            end
        end
        total++; if (ferr_cnt - f0 !== 0 || perr_cnt - p0 !== 0) begin bad++; $display("FAIL b2b_err got=%0d/%0d exp=0/0", ferr_cnt - f0, perr_cnt - p0); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL b2b_last got=%h exp=3c", data_out); end
    endtask

    task automatic test_glitch();
        snap();
        rx = 1'b0;
        #640;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
        rx = 1'b1;
        #BIT;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
        total++; if (ferr_cnt - f0 !== 0 || perr_cnt - p0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d/%0d exp=0/0", ferr_cnt - f0, perr_cnt - p0); end
    endtask

    task automatic test_break();
        snap();
        send_frame(8'h55, 1'b0);
        #(3*BIT);
        total++; if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL brk_ferr got=%0d exp=1", ferr_cnt - f0); end
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL brk_valid got=%0d exp=0", valid_cnt - v0); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL brk_busy_hi got=%b exp=1", busy); end
        total++; if (data_out !== 8'h55) begin bad++; $display("FAIL brk_data got=%h exp=55", data_out); end
        rx = 1'b1;
        #BIT;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL brk_busy_lo got=%b exp=0", busy); end
        send_frame(8'h12, 1'b1);
        #BIT;
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL brk_next_valid got=%0d exp=1", valid_cnt - v0); end
        total++; if (data_out !== 8'h12) begin bad++; $display("FAIL brk_next_data got=%h exp=12", data_out); end
    endtask

    task automatic test_parity();
        int pv, pp;
        pv = valid_cnt_p;
        pp = perr_cnt_p;
        send_frame_p(8'h07, 1'b0);
        total++; if (perr_cnt_p - pp !== 1) begin bad++; $display("FAIL par_err_cnt got=%0d exp=1", perr_cnt_p - pp); end
        total++; if (valid_cnt_p - pv !== 0) begin bad++; $display("FAIL par_bad_valid got=%0d exp=0", valid_cnt_p - pv); end
        total++; if (data_out_p !== 8'h07) begin bad++; $display("FAIL par_data got=%h exp=07", data_out_p); end
        send_frame_p(8'h07, 1'b1);
        total++; if (valid_cnt_p - pv !== 1) begin bad++; $display("FAIL par_ok_valid got=%0d exp=1", valid_cnt_p - pv); end
        total++; if (perr_cnt_p - pp !== 1 || ferr_cnt_p !== 0) begin bad++; $display("FAIL par_ok_err got=%0d/%0d exp=1/0", perr_cnt_p - pp, ferr_cnt_p); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        b = 8'hC3;
        snap();
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            #BIT;
        end
        rx = b[4];
        #(BIT/2);
        reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data_out); end
        total++; if (data_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b%b exp=000", data_valid, frame_err, parity_err); end
        #(BIT/2);
        for (int i = 5; i < 8; i++) begin
            rx = b[i];
            #BIT;
        end
        rx = 1'b1;
        #BIT;
        @(negedge clk_in);
        reset = 1'b1;
        #BIT;
        total++; if (busy !== 1'b0 || valid_cnt - v0 !== 0) begin bad++; $display("FAIL rst_after got=%b/%0d exp=0/0", busy, valid_cnt - v0); end
        send_frame(8'h81, 1'b1);
        #BIT;
        total++; if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL rst_next_valid got=%0d exp=1", valid_cnt - v0); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL rst_next_data got=%h exp=81", data_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_break();
        test_parity();
        test_mid_reset();
        total++; if (excl_cnt !== 0 || excl_cnt_p !== 0) begin bad++; $display("FAIL exclusive got=%0d/%0d exp=0/0", excl_cnt, excl_cnt_p); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
